// File: rtl/i2c_pkg.sv
// ============================================================================
// Module : i2c_pkg
// Shared I2C widths and protocol-engine state encoding (master and slave).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package i2c_pkg;
    localparam int I2C_ADDR_W  = 7;
    localparam int I2C_DATA_W  = 8;
    localparam int I2C_STATE_W = 4;

    typedef enum logic [I2C_STATE_W-1:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_RX_DATA   = 4'd3,
        ST_RX_ACK    = 4'd4,
        ST_TX_DATA   = 4'd5,
        ST_TX_ACK    = 4'd6,
        ST_WAIT_STOP = 4'd7
    } i2c_state_e;
endpackage

`default_nettype wire

// File: rtl/i2c_bus_sync.sv
// ============================================================================
// Module : i2c_bus_sync
// SCL/SDA synchronizer with history flop; emits SCL edge and START/STOP pulses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_bus_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_hist;
    logic                   r_sda_hist;
    logic                   w_scl;
    logic                   w_sda;

    // Reset to 1 so that an idle bus produces no edge when reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_hist <= w_scl;
            r_sda_hist <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign o_sda      = w_sda;
    assign o_scl_rise =  w_scl & ~r_scl_hist;
    assign o_scl_fall = ~w_scl &  r_scl_hist;
    assign o_start    =  w_scl &  r_scl_hist &  r_sda_hist & ~w_sda;
    assign o_stop     =  w_scl &  r_scl_hist & ~r_sda_hist &  w_sda;
endmodule

`default_nettype wire

// File: rtl/i2c_slave_fsm.sv
// ============================================================================
// Module : i2c_slave_fsm
// 7-bit-address I2C target engine between pad logic and RX/TX FIFOs.
// Optional clock stretching: define I2C_SLAVE_CLK_STRETCH_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_slave_fsm
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h3C,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  i2c_core_clk_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic                  i2c_scl_i,
    input  logic                  i2c_sda_i,
    output logic                  sda_low_en_o,
    output logic                  scl_low_en_o,
    output logic [I2C_DATA_W-1:0] rx_data_o,
    output logic                  rx_wr_en_o,
    input  logic                  rx_full_i,
    input  logic [I2C_DATA_W-1:0] tx_data_i,
    output logic                  tx_rd_en_o,
    input  logic                  tx_empty_i,
    output logic                  busy_o,
    output logic                  rw_o,
    output logic                  stop_o
);
    logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (i2c_core_clk_i),
        .rst        (reset_i),
        .i_scl      (i2c_scl_i),
        .i_sda      (i2c_sda_i),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    i2c_state_e            r_state, w_state_nxt;
    logic [3:0]            r_bit_cnt, w_bit_cnt_nxt;
    logic [I2C_DATA_W-1:0] r_shift, w_shift_nxt;
    logic [I2C_DATA_W-1:0] r_rx_data, w_rx_data_nxt;
    logic                  r_rw, w_rw_nxt;
    logic                  r_sda_low, w_sda_low_nxt;
    logic                  r_rx_wr, w_rx_wr_nxt;
    logic                  r_tx_rd, w_tx_rd_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_stop, w_stop_nxt;
    logic                  r_ack, w_ack_nxt;
    logic                  r_tx_load, w_tx_load_nxt;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    logic                  r_scl_low, w_scl_low_nxt;
`endif

    always_ff @(posedge i2c_core_clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 4'd0;
            r_shift   <= '0;
            r_rx_data <= '0;
            r_rw      <= 1'b0;
            r_sda_low <= 1'b0;
            r_rx_wr   <= 1'b0;
            r_tx_rd   <= 1'b0;
            r_busy    <= 1'b0;
            r_stop    <= 1'b0;
            r_ack     <= 1'b0;
            r_tx_load <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            r_scl_low <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_rx_data <= w_rx_data_nxt;
            r_rw      <= w_rw_nxt;
            r_sda_low <= w_sda_low_nxt;
            r_rx_wr   <= w_rx_wr_nxt;
            r_tx_rd   <= w_tx_rd_nxt;
            r_busy    <= w_busy_nxt;
            r_stop    <= w_stop_nxt;
            r_ack     <= w_ack_nxt;
            r_tx_load <= w_tx_load_nxt;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            r_scl_low <= w_scl_low_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_rx_data_nxt = r_rx_data;
        w_rw_nxt      = r_rw;
        w_sda_low_nxt = r_sda_low;
        w_rx_wr_nxt   = 1'b0;
        w_tx_rd_nxt   = 1'b0;
        w_busy_nxt    = r_busy;
        w_stop_nxt    = 1'b0;
        w_ack_nxt     = r_ack;
        w_tx_load_nxt = r_tx_load;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        w_scl_low_nxt = r_scl_low;
`endif
        if (!enable_i) begin
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = 4'd0;
            w_rx_data_nxt = '0;
            w_rw_nxt      = 1'b0;
            w_sda_low_nxt = 1'b0;
            w_busy_nxt    = 1'b0;
            w_ack_nxt     = 1'b0;
            w_tx_load_nxt = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            w_scl_low_nxt = 1'b0;
`endif
        end else if (w_start || w_stop) begin
            w_state_nxt   = w_start ? ST_ADDR : ST_IDLE;
            w_bit_cnt_nxt = 4'd0;
            w_sda_low_nxt = 1'b0;
            w_busy_nxt    = w_start;
            w_stop_nxt    = w_stop;
            w_tx_load_nxt = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            w_scl_low_nxt = 1'b0;
`endif
        end else begin
            case (r_state)
                ST_ADDR: begin
                    if (w_scl_rise && r_bit_cnt != 4'd8) begin
                        w_shift_nxt   = {r_shift[I2C_DATA_W-2:0], w_sda};
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                        w_bit_cnt_nxt = 4'd0;
                        if (r_shift[I2C_DATA_W-1:1] == SLAVE_ADDR) begin
                            w_state_nxt   = ST_ADDR_ACK;
                            w_rw_nxt      = r_shift[0];
                            w_sda_low_nxt = 1'b1;
                        end else begin
                            w_state_nxt   = ST_WAIT_STOP;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_bit_cnt_nxt = 4'd0;
                        if (r_rw) begin
                            // ACK stays driven until the TX entry cycle sets bit 7.
                            w_state_nxt   = ST_TX_DATA;
                            w_tx_load_nxt = 1'b1;
                        end else begin
                            w_state_nxt   = ST_RX_DATA;
                            w_sda_low_nxt = 1'b0;
                        end
                    end
                end
                ST_RX_DATA: begin
                    // Count 8 = byte complete; 9 = complete and 8th SCL fall already seen.
                    if (r_bit_cnt < 4'd8) begin
                        if (w_scl_rise) begin
                            w_shift_nxt   = {r_shift[I2C_DATA_W-2:0], w_sda};
                            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        end
                    end else if (!rx_full_i) begin
                        w_rx_data_nxt = r_shift;
                        w_rx_wr_nxt   = 1'b1;
                        w_ack_nxt     = 1'b1;
                        w_state_nxt   = ST_RX_ACK;
                        if (r_bit_cnt == 4'd9)
                            w_sda_low_nxt = 1'b1;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                        w_scl_low_nxt = 1'b0;
`endif
                    end else begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                        if (w_scl_fall) begin
                            w_bit_cnt_nxt = 4'd9;
                            w_scl_low_nxt = 1'b1;
                        end
`else
                        w_ack_nxt     = 1'b0;
                        w_state_nxt   = ST_RX_ACK;
`endif
                    end
                end
                ST_RX_ACK: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_sda_low_nxt = r_ack;
                            w_bit_cnt_nxt = 4'd9;
                        end else begin
                            w_sda_low_nxt = 1'b0;
                            w_bit_cnt_nxt = 4'd0;
                            w_state_nxt   = r_ack ? ST_RX_DATA : ST_WAIT_STOP;
                        end
                    end
                end
                ST_TX_DATA: begin
                    if (r_tx_load) begin
                        if (!tx_empty_i) begin
                            w_tx_rd_nxt   = 1'b1;
                            w_shift_nxt   = tx_data_i;
                            w_sda_low_nxt = ~tx_data_i[I2C_DATA_W-1];
                            w_tx_load_nxt = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                            w_scl_low_nxt = 1'b0;
`endif
                        end else begin
                            w_sda_low_nxt = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                            w_scl_low_nxt = 1'b1;
`else
                            w_shift_nxt   = 8'hFF;
                            w_tx_load_nxt = 1'b0;
`endif
                        end
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd7) begin
                            w_state_nxt   = ST_TX_ACK;
                            w_sda_low_nxt = 1'b0;
                            w_bit_cnt_nxt = 4'd0;
                            w_ack_nxt     = 1'b0;
                        end else begin
                            w_shift_nxt   = {r_shift[I2C_DATA_W-2:0], 1'b0};
                            w_sda_low_nxt = ~r_shift[I2C_DATA_W-2];
                            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (w_scl_rise) begin
                        if (w_sda)
                            w_state_nxt = ST_WAIT_STOP;
                        else
                            w_ack_nxt   = 1'b1;
                    end else if (w_scl_fall && r_ack) begin
                        w_state_nxt   = ST_TX_DATA;
                        w_tx_load_nxt = 1'b1;
                        w_bit_cnt_nxt = 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_low_en_o = r_sda_low;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    assign scl_low_en_o = r_scl_low;
`else
    assign scl_low_en_o = 1'b0;
`endif
    assign rx_data_o    = r_rx_data;
    assign rx_wr_en_o   = r_rx_wr;
    assign tx_rd_en_o   = r_tx_rd;
    assign busy_o       = r_busy;
    assign rw_o         = r_rw;
    assign stop_o       = r_stop;
endmodule

`default_nettype wire
